// File: rtl/reflet_regbank_if.sv
// Commit/read bus between the Reflet pipeline units and the architectural register bank.
// The core side is the master. The register bank is the slave.
interface reflet_regbank_if #(
  parameter int wordsize   = 16,
  parameter int reg_addr_w = 4,
  parameter int cnt_w      = 32
);
  logic                  enable;
  logic                  stall;
  logic                  wa_en;
  logic [reg_addr_w-1:0] wa_idx;
  logic [wordsize-1:0]   wa_data;
  logic                  wb_en;
  logic [reg_addr_w-1:0] wb_idx;
  logic [wordsize-1:0]   wb_data;
  logic [1:0]            sp_op;
  logic                  irq_take;
  logic [wordsize-1:0]   irq_vector;
  logic                  quit_req;
  logic                  resume;
  logic [reg_addr_w-1:0] rd_idx;
  logic [wordsize-1:0]   rd_data;
  logic [wordsize-1:0]   wr_out;
  logic [wordsize-1:0]   sr_out;
  logic [wordsize-1:0]   pc_out;
  logic [wordsize-1:0]   sp_out;
  logic                  quit;
  logic [cnt_w-1:0]      retire_cnt;

  modport master (
    output enable, stall, wa_en, wa_idx, wa_data, wb_en, wb_idx, wb_data,
           sp_op, irq_take, irq_vector, quit_req, resume, rd_idx,
    input  rd_data, wr_out, sr_out, pc_out, sp_out, quit, retire_cnt
  );

  modport slave (
    input  enable, stall, wa_en, wa_idx, wa_data, wb_en, wb_idx, wb_data,
           sp_op, irq_take, irq_vector, quit_req, resume, rd_idx,
    output rd_data, wr_out, sr_out, pc_out, sp_out, quit, retire_cnt
  );
endinterface

// File: rtl/reflet_regbank.sv
// Reflet architectural register bank and commit controller. It applies the two write ports,
// the SP adjust, the PC step, interrupt redirects and the quit/resume halt once per retiring instruction.
//
// state   | meaning
// st_run  | instructions commit whenever enabled and not stalled
// st_halt | quit latched; only resume (with enable) leaves
module reflet_regbank #(
  parameter int                 wordsize   = 16,
  parameter int                 reg_addr_w = 4,
  parameter int                 wr_id      = 0,
  parameter int                 sr_id      = 2**reg_addr_w - 3,
  parameter int                 pc_id      = 2**reg_addr_w - 2,
  parameter int                 sp_id      = 2**reg_addr_w - 1,
  parameter int                 sp_step    = wordsize / 8,
  parameter logic [wordsize-1:0] pc_reset  = '0,
  parameter logic [wordsize-1:0] sp_reset  = '0,
  parameter logic [wordsize-1:0] sr_reset  = '0,
  parameter int                 cnt_w      = 32
) (
  input logic           clk,
  input logic           reset,
  reflet_regbank_if.slave bus
);

  localparam int                    nregs    = 2**reg_addr_w;
  localparam logic [reg_addr_w-1:0] wr_ix    = reg_addr_w'(wr_id);
  localparam logic [reg_addr_w-1:0] sr_ix    = reg_addr_w'(sr_id);
  localparam logic [reg_addr_w-1:0] pc_ix    = reg_addr_w'(pc_id);
  localparam logic [reg_addr_w-1:0] sp_ix    = reg_addr_w'(sp_id);
  localparam logic [wordsize-1:0]   sp_delta = wordsize'(sp_step);

  typedef enum logic {
    st_run  = 1'b0,
    st_halt = 1'b1
  } state_t;

  state_t              state, state_nx;
  logic [wordsize-1:0] regs    [nregs];
  logic [wordsize-1:0] regs_nx [nregs];
  logic [cnt_w-1:0]    cnt, cnt_nx;
  logic                commit;
  logic                pc_hit;

  function automatic logic [wordsize-1:0] reset_val(input int i);
    if (i == sr_id)      return sr_reset;
    else if (i == pc_id) return pc_reset;
    else if (i == sp_id) return sp_reset;
    else                 return '0;
  endfunction

  assign commit = bus.enable && (state == st_run) && !bus.stall;
  assign pc_hit = (bus.wa_en && (bus.wa_idx == pc_ix)) || (bus.wb_en && (bus.wb_idx == pc_ix));

  always_comb begin
    state_nx = state;
    case (state)
      st_run:  if (commit && !bus.irq_take && bus.quit_req) state_nx = st_halt;
      st_halt: if (bus.enable && bus.resume) state_nx = st_run;
      default: state_nx = st_run;
    endcase
  end

  // Later assignments override earlier ones: SP adjust, then port B, then port A, then the PC step.
  always_comb begin
    regs_nx = regs;
    cnt_nx  = cnt;
    if (commit) begin
      if (bus.irq_take) begin
        regs_nx[pc_ix] = bus.irq_vector;
      end else begin
        case (bus.sp_op)
          2'b01:   regs_nx[sp_ix] = regs[sp_ix] + sp_delta;
          2'b10:   regs_nx[sp_ix] = regs[sp_ix] - sp_delta;
          default: ;
        endcase
        if (bus.wb_en) regs_nx[bus.wb_idx] = bus.wb_data;
        if (bus.wa_en) regs_nx[bus.wa_idx] = bus.wa_data;
        if (!pc_hit)   regs_nx[pc_ix] = regs[pc_ix] + wordsize'(1);
        cnt_nx = cnt + cnt_w'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= st_run;
      cnt   <= '0;
      for (int i = 0; i < nregs; i++) regs[i] <= reset_val(i);
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      for (int i = 0; i < nregs; i++) regs[i] <= regs_nx[i];
    end
  end

  assign bus.rd_data    = regs[bus.rd_idx];
  assign bus.wr_out     = regs[wr_ix];
  assign bus.sr_out     = regs[sr_ix];
  assign bus.pc_out     = regs[pc_ix];
  assign bus.sp_out     = regs[sp_ix];
  assign bus.quit       = (state == st_halt);
  assign bus.retire_cnt = cnt;

endmodule

// File: tb/tb_reflet_regbank.sv
// Bench for reflet_regbank: directed scenarios plus a random run, all compared
// against an instruction-level model of the register file.
`timescale 1ns/1ps
module tb_reflet_regbank;
  localparam int WS    = 16;
  localparam int AW    = 4;
  localparam int CW    = 32;
  localparam int NR    = 16;
  localparam int WR_ID = 0;
  localparam int SR_ID = 13;
  localparam int PC_ID = 14;
  localparam int SP_ID = 15;
  localparam int STEP  = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reflet_regbank_if #(.wordsize(WS), .reg_addr_w(AW), .cnt_w(CW)) bus ();

  reflet_regbank #(.wordsize(WS), .reg_addr_w(AW), .cnt_w(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [WS-1:0] m_reg [NR];
  logic [CW-1:0] m_cnt;
  bit            m_quit;

  task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One instruction's architectural effect, computed from the current inputs.
  task automatic model_step();
    int unsigned old_pc;
    bit          pc_written;
    if (!reset) begin
      foreach (m_reg[i]) m_reg[i] = '0;
      m_cnt  = '0;
      m_quit = 0;
    end else if (bus.enable && m_quit) begin
      if (bus.resume) m_quit = 0;
    end else if (bus.enable && !bus.stall) begin
      if (bus.irq_take) begin
        m_reg[PC_ID] = bus.irq_vector;
      end else begin
        old_pc     = m_reg[PC_ID];
        pc_written = (bus.wa_en && bus.wa_idx == PC_ID) || (bus.wb_en && bus.wb_idx == PC_ID);
        if (bus.sp_op == 2'b01) m_reg[SP_ID] = WS'((int'(m_reg[SP_ID]) + STEP) % 65536);
        if (bus.sp_op == 2'b10) m_reg[SP_ID] = WS'((int'(m_reg[SP_ID]) + 65536 - STEP) % 65536);
        if (bus.wb_en) m_reg[bus.wb_idx] = bus.wb_data;
        if (bus.wa_en) m_reg[bus.wa_idx] = bus.wa_data;
        if (!pc_written) m_reg[PC_ID] = WS'((old_pc + 1) % 65536);
        if (bus.quit_req) m_quit = 1;
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic check_all();
    chk("wr_out", CW'(bus.wr_out), CW'(m_reg[WR_ID]));
    chk("sr_out", CW'(bus.sr_out), CW'(m_reg[SR_ID]));
    chk("pc_out", CW'(bus.pc_out), CW'(m_reg[PC_ID]));
    chk("sp_out", CW'(bus.sp_out), CW'(m_reg[SP_ID]));
    chk("quit", CW'(bus.quit), CW'(m_quit));
    chk("retire_cnt", bus.retire_cnt, m_cnt);
    for (int i = 0; i < NR; i++) begin
      bus.rd_idx = AW'(i);
      #0.2;
      chk($sformatf("rd_data[%0d]", i), CW'(bus.rd_data), CW'(m_reg[i]));
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    reset          = 1'b1;
    bus.enable     = 1'b1;
    bus.stall      = 1'b0;
    bus.wa_en      = 1'b0;
    bus.wa_idx     = '0;
    bus.wa_data    = '0;
    bus.wb_en      = 1'b0;
    bus.wb_idx     = '0;
    bus.wb_data    = '0;
    bus.sp_op      = 2'b00;
    bus.irq_take   = 1'b0;
    bus.irq_vector = '0;
    bus.quit_req   = 1'b0;
    bus.resume     = 1'b0;
  endtask

  task automatic wa(input int idx, input logic [WS-1:0] d);
    bus.wa_en = 1'b1; bus.wa_idx = AW'(idx); bus.wa_data = d;
  endtask

  task automatic wb(input int idx, input logic [WS-1:0] d);
    bus.wb_en = 1'b1; bus.wb_idx = AW'(idx); bus.wb_data = d;
  endtask

  initial begin
    bus.rd_idx = '0;
    idle();
    reset = 1'b0;
    tick(); tick();
    chk("reset_pc", CW'(bus.pc_out), 32'h0);
    chk("reset_cnt", bus.retire_cnt, 32'h0);

    idle();
    repeat (3) tick();
    chk("three_commits_pc", CW'(bus.pc_out), 32'h3);
    chk("three_commits_cnt", bus.retire_cnt, 32'h3);

    idle(); wa(3, 16'hBEEF); wb(3, 16'h1234); tick();
    bus.rd_idx = 4'd3; #0.2;
    chk("a_wins_over_b", CW'(bus.rd_data), 32'hBEEF);
    chk("pc_after_dual", CW'(bus.pc_out), 32'h4);
    idle(); wa(3, 16'h5A5A); wb(4, 16'h1234); tick();

    idle(); bus.sp_op = 2'b10; tick();
    chk("sp_wrap_down", CW'(bus.sp_out), 32'hFFFE);
    idle(); bus.sp_op = 2'b01; wa(SP_ID, 16'h0100); tick();
    chk("sp_write_over_op", CW'(bus.sp_out), 32'h0100);
    idle(); bus.sp_op = 2'b11; tick();

    idle(); wa(PC_ID, 16'h0040); tick();
    chk("pc_write_no_inc", CW'(bus.pc_out), 32'h0040);
    idle(); bus.irq_take = 1'b1; bus.irq_vector = 16'h0200; wa(5, 16'h7777);
    bus.sp_op = 2'b01; bus.quit_req = 1'b1; tick();
    chk("irq_vector", CW'(bus.pc_out), 32'h0200);
    chk("irq_no_retire", bus.retire_cnt, 32'h9);

    idle(); bus.stall = 1'b1; wa(6, 16'hCAFE); repeat (4) tick();
    bus.stall = 1'b0; tick();
    idle(); bus.enable = 1'b0; wa(7, 16'hF00D); bus.resume = 1'b1; repeat (4) tick();

    idle(); bus.quit_req = 1'b1; wa(1, 16'hAAAA); tick();
    chk("quit_set", CW'(bus.quit), 32'h1);
    idle(); wa(2, 16'h2222); repeat (3) tick();
    idle(); bus.stall = 1'b1; bus.resume = 1'b1; tick();
    chk("resume_clear", CW'(bus.quit), 32'h0);
    idle(); wa(2, 16'h3333); tick();
    idle(); bus.quit_req = 1'b1; tick();
    idle(); reset = 1'b0; tick();
    chk("reset_mid_halt", CW'(bus.quit), 32'h0);

    for (int n = 0; n < 1500; n++) begin
      idle();
      reset          = ($urandom_range(0, 99) != 0);
      bus.enable     = ($urandom_range(0, 9) != 0);
      bus.stall      = ($urandom_range(0, 4) == 0);
      bus.wa_en      = $urandom_range(0, 1);
      bus.wa_idx     = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(PC_ID, SP_ID)) : AW'($urandom);
      bus.wa_data    = WS'($urandom);
      bus.wb_en      = $urandom_range(0, 1);
      bus.wb_idx     = ($urandom_range(0, 3) == 0) ? bus.wa_idx : AW'($urandom);
      bus.wb_data    = WS'($urandom);
      bus.sp_op      = 2'($urandom);
      bus.irq_take   = ($urandom_range(0, 9) == 0);
      bus.irq_vector = WS'($urandom);
      bus.quit_req   = ($urandom_range(0, 19) == 0);
      bus.resume     = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
